// File: rtl/multicycle_cpu_if.sv
// Shared instruction/data memory port; an access completes at the edge where mem_req and mem_ready are both high.
// The master holds request fields stable until mem_ready; the slave may insert any number of wait cycles.
interface multicycle_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: j 2, beq/bne 3, R/addi/sw 4, lw 5 cycles with zero-wait memory.
// Each mem_ready wait cycle stalls FETCH/MEM by one cycle with the request held stable.
module multicycle_cpu #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_cpu_if.master  mem,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted,
  output logic              fault
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              fault_q, fault_d;
  logic [31:0]       regs_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_addr;
  logic [31:0] sext_imm, br_off, pc_ext, j_tgt, ea, r_res, wb_val;
  logic        legal, br_taken;
  logic        unused_ok;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {sext_imm[29:0], 2'b00};
  assign pc_ext   = 32'(pc_q);
  assign j_tgt    = {pc_ext[31:28], ir_q[25:0], 2'b00};
  assign ea       = a_q + sext_imm;
  assign br_taken = (a_q == b_q) ^ (opcode == OP_BNE);
  assign legal    = ((opcode == OP_RTYPE) && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}))
                 || (opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE});
  assign wb_addr  = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_val   = (opcode == OP_LW) ? mdr_q : alu_q;
  // shamt and the PC bits below the jump region never influence results
  assign unused_ok = ^{ir_q[10:6], pc_ext[27:0], br_off, j_tgt};

  always_comb begin
    case (funct)
      FN_SUB:  r_res = a_q - b_q;
      FN_AND:  r_res = a_q & b_q;
      FN_OR:   r_res = a_q | b_q;
      FN_SLT:  r_res = {31'b0, $signed(a_q) < $signed(b_q)};
      default: r_res = a_q + b_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    tgt_d   = tgt_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = regs_q[rs];
        b_d   = regs_q[rt];
        tgt_d = pc_q + br_off[ADDR_W-1:0];
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode == OP_J) begin
          pc_d    = j_tgt[ADDR_W-1:0];
          state_d = S_FETCH;
        end else if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin alu_d = r_res;          state_d = S_WB; end
          OP_ADDI:  begin alu_d = a_q + sext_imm; state_d = S_WB; end
          OP_LW, OP_SW: begin
            alu_d = ea;
            if (ea[1:0] != 2'b00) begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_BEQ, OP_BNE: begin
            if (br_taken) pc_d = tgt_q;
            state_d = S_FETCH;
          end
          default: begin state_d = S_HALT; fault_d = 1'b1; end
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      fault_q <= fault_d;
      // r0 is never written, so reads of it stay zero
      if (state_q == S_WB && wb_addr != 5'd0) regs_q[wb_addr] <= wb_val;
    end
  end

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = pc_q;
    mem.mem_wdata = b_q;
    retire        = 1'b0;
    case (state_q)
      S_FETCH:  mem.mem_req = 1'b1;
      S_DECODE: retire = (opcode == OP_J);
      S_EXEC:   retire = (opcode == OP_BEQ) || (opcode == OP_BNE);
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = (opcode == OP_SW);
        mem.mem_addr = alu_q[ADDR_W-1:0];
        retire       = mem.mem_ready && (opcode == OP_SW);
      end
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
    if (rst) begin
      mem.mem_req = 1'b0;
      retire      = 1'b0;
    end
  end

  assign pc_out = pc_q;
  assign halted = (state_q == S_HALT);
  assign fault  = fault_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Drives multicycle_cpu (8-bit addresses, reset PC 0x40) from a wait-state memory model and
// scoreboards memory accesses and retire latencies against an instruction-level reference model.
module tb_multicycle_cpu;
  localparam int              AW     = 8;
  localparam int              AMASK  = (1 << AW) - 1;
  localparam logic [AW-1:0]   RPC    = 8'h40;
  localparam int              NW     = 64;
  localparam logic [31:0]     HALT_W = 32'hFC000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_out;
  logic          retire, halted, fault;

  multicycle_cpu_if #(.ADDR_W(AW)) bus ();

  multicycle_cpu #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem(bus),
    .pc_out(pc_out), .retire(retire), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {bit we; int addr; int wdata;} acc_t;

  acc_t        exp_acc[$];
  int          exp_lat[$];
  int          checks = 0, errors = 0;
  logic [31:0] mem [NW];
  logic [31:0] img [NW];
  logic [31:0] mm  [NW];
  int          regs [32];
  int          wait_cfg = 0;
  bit          expect_halt = 1'b0, start_pending = 1'b0;
  int          ret_cnt = 0, cyc = 0, last_ret = 0, first_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int t);
    return {6'h02, 26'(t)};
  endfunction

  // Memory responder: ready after wait_cfg stall cycles, writes land at the completing edge
  logic          rsp_we = 1'b0;
  logic [AW-1:0] rsp_addr = '0;
  logic [31:0]   rsp_wdata = '0;
  int            wcnt = 0;
  always @(posedge clk) begin
    #2;
    if (bus.mem_ready === 1'b1) begin
      if (rsp_we) mem[rsp_addr[7:2]] = rsp_wdata;
      wcnt = 0;
    end
    if (bus.mem_req === 1'b1) begin
      if (wcnt >= wait_cfg) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[7:2]];
        rsp_we    = bus.mem_we;
        rsp_addr  = bus.mem_addr;
        rsp_wdata = bus.mem_wdata;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: pops expected accesses and retire latencies as the DUT presents them
  acc_t pend, e;
  bit   pend_v = 1'b0;
  int   lat_e;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (start_pending && bus.mem_req) begin
        last_ret      = cyc - 1;
        start_pending = 1'b0;
      end
      if (pend_v && bus.mem_req) begin
        chk("hold_addr", 32'(bus.mem_addr), pend.addr);
        chk("hold_we", 32'(bus.mem_we), 32'(pend.we));
        if (pend.we) chk("hold_wdata", bus.mem_wdata, pend.wdata);
      end
      pend_v = bus.mem_req && !bus.mem_ready;
      if (pend_v) begin
        pend.we = bus.mem_we; pend.addr = int'(bus.mem_addr); pend.wdata = bus.mem_wdata;
      end
      if (bus.mem_req && bus.mem_ready) begin
        if (exp_acc.size() > 0) begin
          e = exp_acc.pop_front();
          chk("acc_we", 32'(bus.mem_we), 32'(e.we));
          chk("acc_addr", 32'(bus.mem_addr), e.addr);
          if (e.we) chk("acc_wdata", bus.mem_wdata, e.wdata);
        end else if (expect_halt) begin
          checks++; errors++;
          $display("FAIL extra_access actual addr=%02h expected none", bus.mem_addr);
        end
      end
      if (retire) begin
        ret_cnt++;
        if (ret_cnt == 1) first_lat = cyc - last_ret;
        if (exp_lat.size() > 0) begin
          lat_e = exp_lat.pop_front();
          chk("retire_lat", cyc - last_ret, lat_e);
        end else if (expect_halt) begin
          checks++; errors++;
          $display("FAIL extra_retire actual count=%0d expected fewer", ret_cnt);
        end
        last_ret = cyc;
      end
    end
  end

  // Instruction-level reference: executes from img, queues expected accesses and per-instruction cycles
  task automatic model_run(input int max_steps, output bit m_halt, output bit m_fault,
                           output int m_pc, output int n_ret);
    int   pc, ir, op, rs, rt, rd, fn, simm, addr, lat;
    acc_t a;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    mm = img;
    exp_acc.delete();
    exp_lat.delete();
    pc = int'(RPC); m_halt = 1'b0; m_fault = 1'b0; n_ret = 0;
    while (!m_halt && n_ret < max_steps) begin
      ir = int'(mm[pc >> 2]);
      a.we = 1'b0; a.addr = pc; a.wdata = 0;
      exp_acc.push_back(a);
      pc = (pc + 4) & AMASK;
      op = (ir >> 26) & 63; rs = (ir >> 21) & 31; rt = (ir >> 16) & 31;
      rd = (ir >> 11) & 31; fn = ir & 63;
      simm = ir & 32'hFFFF;
      if (simm >= 32768) simm = simm - 65536;
      lat = 0;
      case (op)
        63: m_halt = 1'b1;
        2:  begin pc = ((pc & 32'hF0000000) | ((ir & 32'h03FFFFFF) << 2)) & AMASK; lat = 2 + wait_cfg; end
        4, 5: begin
          if ((op == 4) == (regs[rs] == regs[rt])) pc = (pc + simm * 4) & AMASK;
          lat = 3 + wait_cfg;
        end
        8: begin if (rt != 0) regs[rt] = regs[rs] + simm; lat = 4 + wait_cfg; end
        0: begin
          lat = 4 + wait_cfg;
          case (fn)
            32: if (rd != 0) regs[rd] = regs[rs] + regs[rt];
            34: if (rd != 0) regs[rd] = regs[rs] - regs[rt];
            36: if (rd != 0) regs[rd] = regs[rs] & regs[rt];
            37: if (rd != 0) regs[rd] = regs[rs] | regs[rt];
            42: if (rd != 0) regs[rd] = (regs[rs] < regs[rt]) ? 1 : 0;
            default: begin m_halt = 1'b1; m_fault = 1'b1; end
          endcase
        end
        35, 43: begin
          addr = (regs[rs] + simm) & AMASK;
          if ((addr & 3) != 0) begin
            m_halt = 1'b1; m_fault = 1'b1;
          end else begin
            a.we = (op == 43); a.addr = addr; a.wdata = (op == 43) ? regs[rt] : 0;
            exp_acc.push_back(a);
            if (op == 43) begin
              mm[addr >> 2] = regs[rt];
              lat = 4 + 2 * wait_cfg;
            end else begin
              if (rt != 0) regs[rt] = int'(mm[addr >> 2]);
              lat = 5 + 2 * wait_cfg;
            end
          end
        end
        default: begin m_halt = 1'b1; m_fault = 1'b1; end
      endcase
      if (!m_halt) begin
        exp_lat.push_back(lat);
        n_ret++;
      end
    end
    m_pc = pc;
  endtask

  task automatic run_prog(input string tag, input int w, input int max_steps);
    bit mh, mf;
    int mpc, nret, budget;
    wait_cfg = w;
    @(posedge clk); #1 rst = 1'b1;
    model_run(max_steps, mh, mf, mpc, nret);
    mem = img;
    expect_halt = mh;
    @(negedge clk);
    chk({tag, "_rst_req_low"}, 32'(bus.mem_req), 0);
    @(posedge clk);
    @(posedge clk); #1;
    ret_cnt = 0; start_pending = 1'b1; rst = 1'b0;
    @(negedge clk);
    chk({tag, "_first_req"}, 32'(bus.mem_req), 1);
    chk({tag, "_first_addr"}, 32'(bus.mem_addr), 32'(RPC));
    chk({tag, "_rst_pc"}, 32'(pc_out), 32'(RPC));
    chk({tag, "_rst_flags"}, {29'b0, retire, halted, fault}, 0);
    for (budget = 0; budget < 4000; budget++) begin
      if (mh ? (halted === 1'b1) : (ret_cnt >= nret)) break;
      @(negedge clk);
    end
    if (budget >= 4000) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual retires=%0d expected %0d", tag, ret_cnt, nret);
    end
    if (mh) begin
      repeat (2) @(negedge clk);
      chk({tag, "_halted"}, 32'(halted), 1);
      chk({tag, "_fault"}, 32'(fault), 32'(mf));
      chk({tag, "_pc_halt"}, 32'(pc_out), mpc);
      chk({tag, "_retires"}, ret_cnt, nret);
      chk({tag, "_lat_left"}, exp_lat.size(), 0);
    end
    chk({tag, "_acc_left"}, exp_acc.size(), 0);
  endtask

  task automatic clear_img();
    for (int i = 0; i < NW; i++) img[i] = HALT_W;
  endtask

  task automatic gen_random();
    int p, n, r;
    clear_img();
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    p = 16;
    n = $urandom_range(8, 16);
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: img[p] = enc_i(8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
        2: img[p] = enc_i(35, 0, $urandom_range(0, 7), 4 * $urandom_range(0, 15));
        3: img[p] = enc_i(43, 0, $urandom_range(0, 7), 4 * $urandom_range(0, 15));
        4: img[p] = enc_i($urandom_range(0, 1) ? 4 : 5, $urandom_range(0, 7), $urandom_range(0, 7), 1);
        default: begin
          case ($urandom_range(0, 4))
            0: img[p] = enc_r(32, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            1: img[p] = enc_r(34, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            2: img[p] = enc_r(36, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            3: img[p] = enc_r(37, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            default: img[p] = enc_r(42, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
          endcase
        end
      endcase
      p++;
    end
    for (int k = 1; k < 8; k++) begin
      img[p] = enc_i(43, 0, k, (k - 1) * 4);
      p++;
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    clear_img();
    img[16] = enc_i(8, 0, 1, 5);
    img[17] = enc_i(8, 0, 2, -3);
    img[18] = enc_r(32, 1, 2, 3);
    img[19] = enc_r(42, 2, 1, 4);
    img[20] = enc_i(43, 0, 3, 0);
    img[21] = enc_i(43, 0, 4, 4);
    run_prog("arith", 0, 1000);
    chk("arith_sum", mem[0], 32'h00000002);
    chk("arith_slt", mem[1], 32'h00000001);
    chk("arith_lat", first_lat, 4);
    chk("arith_nret", ret_cnt, 6);

    clear_img();
    img[2]  = 32'hDEADBEEF;
    img[16] = enc_i(35, 0, 5, 8);
    img[17] = enc_i(43, 0, 5, 12);
    run_prog("lwwait", 3, 1000);
    chk("lwwait_data", mem[3], 32'hDEADBEEF);
    chk("lwwait_lat", first_lat, 11);

    clear_img();
    img[16] = enc_i(4, 0, 0, -1);
    run_prog("beqloop", 0, 4);
    chk("beqloop_lat", first_lat, 3);

    clear_img();
    img[16] = enc_i(5, 0, 0, 5);
    run_prog("bnefall", 0, 1000);
    chk("bnefall_pc", 32'(pc_out), 32'h48);
    chk("bnefall_lat", first_lat, 3);

    clear_img();
    img[16] = enc_i(8, 0, 1, 6);
    img[17] = enc_i(35, 1, 2, 0);
    run_prog("misalign", 0, 1000);
    chk("misalign_fault", 32'(fault), 1);
    chk("misalign_pc", 32'(pc_out), 32'h48);

    clear_img();
    img[16] = 32'hF8000000;
    run_prog("badop", 1, 1000);
    chk("badop_fault", 32'(fault), 1);
    chk("badop_pc", 32'(pc_out), 32'h44);

    clear_img();
    img[16] = enc_j(32'h3F);
    img[63] = enc_i(8, 0, 1, 7);
    img[0]  = enc_j(32'h123);
    img[35] = enc_i(43, 0, 1, 16);
    run_prog("narrow", 0, 1000);
    chk("narrow_store", mem[4], 32'h00000007);
    chk("narrow_pc", 32'(pc_out), 32'h94);

    for (int t = 0; t < 8; t++) begin
      gen_random();
      run_prog("rnd", $urandom_range(0, 2), 1000);
      for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], mm[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Multi-cycle MIPS-subset processor core, the successor to the single-cycle datapath. One FSM sequences fetch, decode, execute, memory and write-back over several cycles. Instruction and data traffic share one external memory port with a req/ready handshake, so wait-state memories are supported. Adds synchronous reset, `bne`, `j`, a halt instruction, fault trapping and a parametrised address width.

## Interface

**Parameters**

- `ADDR_W`, default 32: byte-address width; legal range 8..32.
- `RESET_PC`, default 0: PC value loaded on reset; must be word aligned.

**Ports**

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` output ADDR_W: byte address; always word aligned while `mem_req` is high.
- `mem_wdata` output 32: store data.
- `mem_rdata` input 32: read data; sampled in the cycle `mem_ready` is high.
- `mem_ready` input 1: access completes at the edge where `mem_req` and `mem_ready` are both high.
- `pc_out` output ADDR_W: current PC.
- `retire` output 1: one-cycle pulse per completed instruction.
- `halted` output 1: core is in HALT.
- `fault` output 1: HALT was entered on an illegal opcode or misaligned access.

## Operation

- **State machine states:** FETCH, DECODE, EXEC, MEM, WB, HALT.
- **Register file:** 32 x 32-bit. `r0` always reads 0, and writes to it are discarded.
- **Reset** (`rst` high at an edge) forces:
  - state = FETCH, PC = `RESET_PC`, all registers = 0;
  - `retire` = 0, `halted` = 0, `fault` = 0.
- **Reset priority:** `rst` overrides every other event. `mem_req` is gated low while `rst` is high. Reset during a pending access abandons that access, and memory must tolerate a dropped request.
- **FETCH**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - Hold until `mem_ready`. On that edge, latch IR = `mem_rdata` and PC <= PC+4 (mod 2^ADDR_W), then go to DECODE.
- **DECODE**
  - Read rs and rt into A and B. Compute branch target = PC + (sext(imm16) << 2), truncated to ADDR_W.
  - Next-state transitions by opcode:
    - 0x3F (halt): go to HALT with `fault`=0.
    - Unlisted opcode, or R-type with an unlisted funct: go to HALT with `fault`=1.
    - `j` (0x02): PC <= (PC & ~0x0FFFFFFF) | (imm26 << 2), truncated to ADDR_W; pulse `retire`; go to FETCH.
    - All other legal opcodes: go to EXEC.
- **EXEC**
  - R-type (opcode 0), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - `addi` (0x08): A + sext(imm16).
  - `lw` (0x23) / `sw` (0x2B): address = A + sext(imm16), truncated to ADDR_W.
  - All arithmetic is 32-bit wrapping; no overflow trap.
  - `beq` (0x04) / `bne` (0x05): if taken, PC <= branch target. Pulse `retire` and go to FETCH.
  - `lw`/`sw` with address bits [1:0] != 0: go to HALT with `fault`=1; no memory access occurs.
  - Otherwise: `lw`/`sw` go to MEM; R-type and `addi` go to WB.
- **MEM**
  - Drive `mem_req`=1, `mem_addr`=ALU result.
  - `sw`: `mem_we`=1, `mem_wdata`=B. On `mem_ready`, pulse `retire` and go to FETCH.
  - `lw`: `mem_we`=0. On `mem_ready`, latch MDR and go to WB.
- **WB**
  - Destination register: rd for R-type; rt for `addi`/`lw`.
  - Write ALU result or MDR to it. Pulse `retire` and go to FETCH.
- **HALT:** absorbing state; only `rst` exits it.
  - `halted`=1; `mem_req`=0; `pc_out` frozen at the address after the halting or faulting instruction.

## Timing

- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are Moore outputs of state plus registers. They stay stable while `mem_req` is high and `mem_ready` is low.
- Memory outputs are don't-care when `mem_req`=0.
- Zero-wait latency (`mem_ready` tied high), counted from FETCH entry to the next FETCH entry:

  | Instruction | Cycles |
  |---|---|
  | `j` | 2 |
  | `beq` / `bne` | 3 |
  | R-type, `addi` | 4 |
  | `sw` | 4 |
  | `lw` | 5 |

- Each wait cycle on a memory access adds exactly 1 cycle.
- `retire` is high for exactly one cycle: the last cycle of the instruction, before the edge that enters FETCH.
- A register written in WB is visible to the DECODE of the next instruction.
- First fetch: `mem_req` rises in the first cycle with `rst` low.

## Test plan

- **Reset:** assert `rst` 2 cycles with `RESET_PC`=0x40, zero-wait memory -> first `mem_req` has `mem_addr`=0x40; `pc_out`=0x40; `retire`, `halted` and `fault` all 0.
- **Arithmetic:** program `addi r1,r0,5`; `addi r2,r0,-3`; `add r3,r1,r2`; `slt r4,r2,r1`; `sw r3,0(r0)`; halt -> store writes 0x00000002 to address 0. Also check r4=1, `halted`=1, `fault`=0, and 5 `retire` pulses over 4+4+4+4+4 cycles.
- **Load with wait states:** `mem_ready` delayed 3 cycles on every access; `lw r5,8(r0)` with mem[8]=0xDEADBEEF -> r5=0xDEADBEEF after 5+3+3=11 cycles. Address and `mem_we` are stable throughout each wait.
- **Branches:** `beq` taken with imm=-1 -> loops back to itself, fetched address repeats. `bne` with equal operands -> falls through to PC+4. Each branch takes 3 cycles.
- **Traps:** `lw` at address 0x6 -> `halted`=1, `fault`=1, and no MEM-stage `mem_req`. Opcode 0x3E -> `fault`=1. Holding `rst` high in HALT -> clean restart at `RESET_PC`.
- **Narrow address:** `ADDR_W`=8, PC 0xFC followed by sequential execution -> next fetch at 0x00. `j` target is truncated to 8 bits.
